// File: rtl/lampfpu_exp_if.sv
// rtl/lampfpu_exp_if.sv - operand/result bundle of the bfloat16 e^x unit
interface lampfpu_exp_if;
  logic        do_exp;
  logic        s_op;
  logic [8:0]  ext_e_op1;
  logic [7:0]  ext_f_op1;
  logic        is_z_op;
  logic        is_inf_op;
  logic        is_snan_op;
  logic        is_qnan_op;
  logic        s_res;
  logic [7:0]  e_res;
  logic [11:0] f_res;
  logic        valid;
  logic        is_overflow;
  logic        is_underflow;
  logic        is_to_round;

  modport master (
    output do_exp, s_op, ext_e_op1, ext_f_op1, is_z_op, is_inf_op, is_snan_op, is_qnan_op,
    input  s_res, e_res, f_res, valid, is_overflow, is_underflow, is_to_round
  );

  modport slave (
    input  do_exp, s_op, ext_e_op1, ext_f_op1, is_z_op, is_inf_op, is_snan_op, is_qnan_op,
    output s_res, e_res, f_res, valid, is_overflow, is_underflow, is_to_round
  );
endinterface

// File: rtl/lampfpu_exp.sv
// rtl/lampfpu_exp.sv - multi-cycle bfloat16 e^x, unrounded post-norm style result
// Optional LAMP_FPU_EXP_LINCORR_EN adds the (1 + r_lo) linear correction multiply in EVAL.
module lampfpu_exp (
  input  logic        clk,
  input  logic        rst,
  lampfpu_exp_if.slave bus
);

  localparam logic [16:0] LOG2E    = 17'h17154;
  localparam logic [15:0] LN2      = 16'hB172;
  localparam int          LUT_AW   = 6;
  localparam logic [16:0] QNAN_E_F = 17'h1FEC0;
  localparam logic signed [43:0] HALF_Q32 = 44'sh0_8000_0000;

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] CONV   = 3'd1;
  localparam logic [2:0] RANGE  = 3'd2;
  localparam logic [2:0] REDUCE = 3'd3;
  localparam logic [2:0] EVAL   = 3'd4;
  localparam logic [2:0] OUT    = 3'd5;

  // e^(idx/64) rounded to unsigned Q1.14; only ever evaluated with constant arguments.
  function automatic logic [14:0] exp_q14(input int idx);
    longint x;
    longint term;
    longint sum;
    x    = longint'(idx) <<< 22;
    term = longint'(1) <<< 28;
    sum  = term;
    for (int n = 1; n < 12; n++) begin
      term = (term * x) / (longint'(n) <<< 28);
      sum  = sum + term;
    end
    return 15'((sum + (longint'(1) <<< 13)) >>> 14);
  endfunction

  logic [14:0] lut [2**LUT_AW];
  for (genvar g = 0; g < 2**LUT_AW; g++) begin : g_lut
    assign lut[g] = exp_q14((g < 32) ? g : g - 64);
  end

  logic [2:0] state;

  logic        s_q;
  logic [8:0]  ext_e_q;
  logic [7:0]  ext_f_q;
  logic        is_z_q;
  logic        is_inf_q;
  logic        is_nan_q;

  logic signed [25:0] x_q;
  logic               big_q;
  logic signed [9:0]  k_q;
  logic [5:0]         r_hi_q;
`ifdef LAMP_FPU_EXP_LINCORR_EN
  logic [9:0]         r_lo_q;
`endif
  logic [29:0]        mn_q;
  logic signed [10:0] e_q;

  // CONV: |x| in Q16 is the 1.7 mantissa shifted by (unbiased exponent + 9).
  logic signed [9:0]  ue;
  logic               big_d;
  logic               tiny;
  logic [3:0]         sh;
  logic [22:0]        mag;
  logic signed [25:0] x_d;

  always_comb begin
    ue    = $signed({1'b0, ext_e_q}) - 10'sd127;
    big_d = (ue >= 10'sd7);
    tiny  = (ue < -10'sd9);
    sh    = 4'(ue + 10'sd9);
    mag   = 23'(ext_f_q) << sh;
    if (big_d || tiny)
      x_d = '0;
    else if (s_q)
      x_d = -$signed({3'b0, mag});
    else
      x_d = $signed({3'b0, mag});
  end

  logic signed [43:0] kprod;
  logic signed [9:0]  k_d;

  always_comb begin
    kprod = 44'(x_q) * 44'($signed({1'b0, LOG2E}));
    k_d   = 10'((kprod + HALF_Q32) >>> 32);
  end

  // REDUCE: |r| < 0.5, so the low 16 bits of X - k*ln2 hold r exactly.
  logic [15:0] k_ext;
  logic [15:0] kln2;
  logic [5:0]  r_hi_d;

  assign k_ext = 16'(k_q);
  assign kln2  = k_ext * LN2;

`ifdef LAMP_FPU_EXP_LINCORR_EN
  logic [15:0] rdiff;
  logic [9:0]  r_lo_d;
  assign rdiff  = x_q[15:0] - kln2;
  assign r_hi_d = rdiff[15:10];
  assign r_lo_d = rdiff[9:0];
`else
  assign r_hi_d = 6'((x_q[15:0] - kln2) >> 10);
`endif

  // EVAL: m in Q1.30, always below 2.0, renormalised to a hidden bit at m[30].
  logic [14:0]        t_val;
  logic [30:0]        m;
  logic [29:0]        mn_d;
  logic signed [10:0] e_d;

  assign t_val = lut[r_hi_q];

`ifdef LAMP_FPU_EXP_LINCORR_EN
  assign m = {16'b0, t_val} * {14'b0, 1'b1, 6'b0, r_lo_q};
`else
  assign m = {t_val, 16'b0};
`endif

  always_comb begin
    mn_d = m[30] ? m[29:0] : {m[28:0], 1'b0};
    e_d  = 11'(k_q) + 11'sd127 - (m[30] ? 11'sd0 : 11'sd1);
  end

  logic        res_s;
  logic [7:0]  res_e;
  logic [11:0] res_f;
  logic        res_ovf;
  logic        res_unf;
  logic        res_rnd;

  always_comb begin
    res_s   = 1'b0;
    res_e   = 8'h00;
    res_f   = 12'h000;
    res_ovf = 1'b0;
    res_unf = 1'b0;
    res_rnd = 1'b0;
    if (is_nan_q) begin
      res_s          = s_q;
      {res_e, res_f} = {QNAN_E_F, 3'b000};
    end else if (is_inf_q) begin
      res_e = s_q ? 8'h00 : 8'hFF;
    end else if (is_z_q) begin
      res_e = 8'h7F;
      res_f = 12'h400;
    end else if (e_q >= 11'sd255 || (big_q && !s_q)) begin
      res_e   = 8'hFF;
      res_ovf = 1'b1;
    end else if (e_q <= 11'sd0 || big_q) begin
      res_unf = 1'b1;
    end else begin
      res_e   = e_q[7:0];
      res_f   = {1'b0, 1'b1, mn_q[29:23], mn_q[22], mn_q[21], |mn_q[20:0]};
      res_rnd = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state            <= IDLE;
      s_q              <= 1'b0;
      ext_e_q          <= '0;
      ext_f_q          <= '0;
      is_z_q           <= 1'b0;
      is_inf_q         <= 1'b0;
      is_nan_q         <= 1'b0;
      x_q              <= '0;
      big_q            <= 1'b0;
      k_q              <= '0;
      r_hi_q           <= '0;
`ifdef LAMP_FPU_EXP_LINCORR_EN
      r_lo_q           <= '0;
`endif
      mn_q             <= '0;
      e_q              <= '0;
      bus.s_res        <= 1'b0;
      bus.e_res        <= '0;
      bus.f_res        <= '0;
      bus.valid        <= 1'b0;
      bus.is_overflow  <= 1'b0;
      bus.is_underflow <= 1'b0;
      bus.is_to_round  <= 1'b0;
    end else begin
      bus.valid <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.do_exp) begin
            s_q      <= bus.s_op;
            ext_e_q  <= bus.ext_e_op1;
            ext_f_q  <= bus.ext_f_op1;
            is_z_q   <= bus.is_z_op;
            is_inf_q <= bus.is_inf_op;
            is_nan_q <= bus.is_snan_op | bus.is_qnan_op;
            state    <= CONV;
          end
        end
        CONV: begin
          x_q   <= x_d;
          big_q <= big_d;
          state <= RANGE;
        end
        RANGE: begin
          k_q   <= k_d;
          state <= REDUCE;
        end
        REDUCE: begin
          r_hi_q <= r_hi_d;
`ifdef LAMP_FPU_EXP_LINCORR_EN
          r_lo_q <= r_lo_d;
`endif
          state  <= EVAL;
        end
        EVAL: begin
          mn_q  <= mn_d;
          e_q   <= e_d;
          state <= OUT;
        end
        OUT: begin
          bus.s_res        <= res_s;
          bus.e_res        <= res_e;
          bus.f_res        <= res_f;
          bus.is_overflow  <= res_ovf;
          bus.is_underflow <= res_unf;
          bus.is_to_round  <= res_rnd;
          bus.valid        <= 1'b1;
          state            <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
